// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/mem/wb
// and drives datapath enables, ALUOp and andi/ori/addi flags.
// Ports: clk, reset (sync, active-high), opcode[5:0] in; PCWrite,
// PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource[1:0],
// ALUOp[1:0], ALUSrcA, ALUSrcB[1:0], RegWrite, RegDst, andi, ori, addi,
// instr_done, state[3:0] out; illegal_op out when ILLEGAL_OP_EN is defined.
// Macro ILLEGAL_OP_EN: unknown opcodes trap (state 12) instead of NOP.
module mips_multicycle_control #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       andi,
  output logic       ori,
  output logic       addi,
  output logic       instr_done,
  output logic [3:0] state
`ifdef ILLEGAL_OP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_andi;
  logic             r_ori;
  logic             r_addi;
  logic             w_last;
  logic             w_waiting;
  logic             w_is_mem;
  logic             w_is_imm;

  assign w_last   = (r_cnt == LAST);
  assign w_is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign w_is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                    (opcode == OP_ORI);

  // Memory-wait states count up until the access completes.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                      (r_state == S_MEMWR)) && !w_last;

  always_comb begin
    w_next      = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (w_last) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end else begin
          w_next  = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          w_is_mem:           w_next = S_MEMADR;
          (opcode == OP_R):   w_next = S_EXEC;
          (opcode == OP_BEQ): w_next = S_BRANCH;
          (opcode == OP_J):   w_next = S_JUMP;
          w_is_imm:           w_next = S_IMMEX;
          default: begin
`ifdef ILLEGAL_OP_EN
            w_next = S_TRAP;
`else
            w_next     = S_FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = w_last ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = w_last;
        w_next     = w_last ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Logical immediates go to the decoder as 11; flags pick and/or.
        ALUOp   = (r_andi || r_ori) ? 2'b11 : 2'b00;
        w_next  = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_OP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_waiting ? r_cnt + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_andi <= 1'b0;
      r_ori  <= 1'b0;
      r_addi <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_andi <= (opcode == OP_ANDI);
      r_ori  <= (opcode == OP_ORI);
      r_addi <= (opcode == OP_ADDI);
    end else if (w_next == S_FETCH) begin
      r_andi <= 1'b0;
      r_ori  <= 1'b0;
      r_addi <= 1'b0;
    end
  end

  assign andi  = r_andi;
  assign ori   = r_ori;
  assign addi  = r_addi;
  assign state = r_state;

`ifdef ILLEGAL_OP_EN
  assign illegal_op = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: two instances (MEM_LAT=1 and 3)
// compared cycle by cycle against an instruction-level sequence model.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       irw;
    logic [1:0] pcs;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       rw;
    logic       rd;
    logic       fa;
    logic       fo;
    logic       fd;
    logic       done;
    logic [3:0] st;
  } ov_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  wire ov_t   a1;
  wire ov_t   a3;
  logic       il1;
  logic       il3;

  int   nvec;
  int   nerr;
  int   lat;
  ov_t  q[$];

  mips_multicycle_control #(.MEM_LAT(1), .CNT_W(3)) d1 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(a1.pcw), .PCWriteCond(a1.pcwc), .IorD(a1.iord),
    .MemRead(a1.mr), .MemWrite(a1.mw), .MemtoReg(a1.m2r),
    .IRWrite(a1.irw), .PCSource(a1.pcs), .ALUOp(a1.aluop),
    .ALUSrcA(a1.srca), .ALUSrcB(a1.srcb), .RegWrite(a1.rw),
    .RegDst(a1.rd), .andi(a1.fa), .ori(a1.fo), .addi(a1.fd),
    .instr_done(a1.done), .state(a1.st)
`ifdef ILLEGAL_OP_EN
    , .illegal_op(il1)
`endif
  );

  mips_multicycle_control #(.MEM_LAT(3), .CNT_W(3)) d3 (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(a3.pcw), .PCWriteCond(a3.pcwc), .IorD(a3.iord),
    .MemRead(a3.mr), .MemWrite(a3.mw), .MemtoReg(a3.m2r),
    .IRWrite(a3.irw), .PCSource(a3.pcs), .ALUOp(a3.aluop),
    .ALUSrcA(a3.srca), .ALUSrcB(a3.srcb), .RegWrite(a3.rw),
    .RegDst(a3.rd), .andi(a3.fa), .ori(a3.fo), .addi(a3.fd),
    .instr_done(a3.done), .state(a3.st)
`ifdef ILLEGAL_OP_EN
    , .illegal_op(il3)
`endif
  );

`ifndef ILLEGAL_OP_EN
  assign il1 = 1'b0;
  assign il3 = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ov_t act();
    return (lat == 1) ? a1 : a3;
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02,
                      6'h08, 6'h0C, 6'h0D};
  endfunction

  function automatic ov_t cyc(int st, logic [5:0] op, bit flags);
    ov_t v = '0;
    v.st = 4'(st);
    if (flags) begin
      v.fa = (op == 6'h0C);
      v.fo = (op == 6'h0D);
      v.fd = (op == 6'h08);
    end
    return v;
  endfunction

  // Expected per-cycle outputs of one whole instruction, from FETCH on.
  function automatic void build(logic [5:0] op, int l);
    ov_t v;
    for (int k = 0; k < l; k++) begin
      v = cyc(0, op, 0);
      v.mr = 1; v.srcb = 2'b01;
      if (k == l - 1) begin v.irw = 1; v.pcw = 1; end
      q.push_back(v);
    end
    v = cyc(1, op, 0);
    v.srcb = 2'b11;
`ifdef ILLEGAL_OP_EN
    q.push_back(v);
    if (!legal(op)) begin
      for (int k = 0; k < 12; k++) q.push_back(cyc(12, op, 0));
      return;
    end
`else
    v.done = !legal(op);
    q.push_back(v);
`endif
    case (op)
      6'h23, 6'h2B: begin
        v = cyc(2, op, 1); v.srca = 1; v.srcb = 2'b10; q.push_back(v);
        for (int k = 0; k < l; k++) begin
          v = cyc(op == 6'h23 ? 3 : 5, op, 1);
          v.iord = 1;
          if (op == 6'h23) v.mr = 1;
          else begin v.mw = 1; v.done = (k == l - 1); end
          q.push_back(v);
        end
        if (op == 6'h23) begin
          v = cyc(4, op, 1); v.rw = 1; v.m2r = 1; v.done = 1;
          q.push_back(v);
        end
      end
      6'h00: begin
        v = cyc(6, op, 1); v.srca = 1; v.aluop = 2'b10; q.push_back(v);
        v = cyc(7, op, 1); v.rw = 1; v.rd = 1; v.done = 1; q.push_back(v);
      end
      6'h04: begin
        v = cyc(8, op, 1); v.srca = 1; v.aluop = 2'b01; v.pcwc = 1;
        v.pcs = 2'b01; v.done = 1; q.push_back(v);
      end
      6'h02: begin
        v = cyc(9, op, 1); v.pcw = 1; v.pcs = 2'b10; v.done = 1;
        q.push_back(v);
      end
      6'h08, 6'h0C, 6'h0D: begin
        v = cyc(10, op, 1); v.srca = 1; v.srcb = 2'b10;
        v.aluop = (op == 6'h08) ? 2'b00 : 2'b11; q.push_back(v);
        v = cyc(11, op, 1); v.rw = 1; v.done = 1; q.push_back(v);
      end
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ov_t e;
    do_reset();
    e = cyc(0, 6'h00, 0);
    e.mr = 1; e.srcb = 2'b01; e.irw = 1; e.pcw = 1;
    nvec++;
    if (a1 !== e) begin
      nerr++;
      $display("FAIL reset_l1 got %h want %h", a1, e);
    end
    e.irw = 0; e.pcw = 0;
    nvec++;
    if (a3 !== e) begin
      nerr++;
      $display("FAIL reset_l3 got %h want %h", a3, e);
    end
    nvec++;
    if ({il1, il3} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_illegal got %b want 00", {il1, il3});
    end
  endtask

  task automatic test_lw_lat1();
    lat = 1; opcode = 6'h23;
    do_reset();
    q.delete(); build(6'h23, 1);
    for (int i = 0; i < q.size(); i++) begin
      nvec++;
      if (act() !== q[i]) begin
        nerr++;
        $display("FAIL lw_l1 cyc%0d got %h want %h", i, act(), q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_lat3();
    lat = 3; opcode = 6'h2B;
    do_reset();
    q.delete(); build(6'h2B, 3);
    for (int i = 0; i < q.size(); i++) begin
      nvec++;
      if (act() !== q[i]) begin
        nerr++;
        $display("FAIL sw_l3 cyc%0d got %h want %h", i, act(), q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[5] = '{6'h00, 6'h04, 6'h0C, 6'h0D, 6'h08};
    lat = 1;
    do_reset();
    foreach (ops[k]) begin
      opcode = ops[k];
      q.delete(); build(ops[k], 1);
      for (int i = 0; i < q.size(); i++) begin
        nvec++;
        if (act() !== q[i]) begin
          nerr++;
          $display("FAIL b2b op%h cyc%0d got %h want %h",
                   ops[k], i, act(), q[i]);
        end
        @(negedge clk);
      end
    end
    nvec++;
    if ({a1.fa, a1.fo, a1.fd, a1.st} !== 7'b0) begin
      nerr++;
      $display("FAIL b2b_tail got %b want 0", {a1.fa, a1.fo, a1.fd, a1.st});
    end
  endtask

  task automatic test_reset_mid();
    lat = 3; opcode = 6'h23;
    do_reset();
    q.delete(); build(6'h23, 3);
    for (int i = 0; i < 7; i++) begin
      nvec++;
      if (act() !== q[i]) begin
        nerr++;
        $display("FAIL rmid cyc%0d got %h want %h", i, act(), q[i]);
      end
      if (i == 6) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    opcode = 6'h0C;
    q.delete(); build(6'h0C, 3);
    for (int i = 0; i < q.size(); i++) begin
      nvec++;
      if (act() !== q[i]) begin
        nerr++;
        $display("FAIL rmid_fresh cyc%0d got %h want %h", i, act(), q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    lat = 1; opcode = 6'h3F;
    do_reset();
    q.delete(); build(6'h3F, 1);
    for (int i = 0; i < q.size(); i++) begin
      nvec++;
      if (act() !== q[i] || il1 !== (q[i].st == 4'd12)) begin
        nerr++;
        $display("FAIL illegal cyc%0d got %h/%b want %h/%b",
                 i, act(), il1, q[i], q[i].st == 4'd12);
      end
      @(negedge clk);
    end
    opcode = 6'h02;
`ifdef ILLEGAL_OP_EN
    do_reset();
`endif
    q.delete(); build(6'h02, 1);
    for (int i = 0; i < q.size(); i++) begin
      nvec++;
      if (act() !== q[i] || il1 !== 1'b0) begin
        nerr++;
        $display("FAIL illegal_after cyc%0d got %h/%b want %h/0",
                 i, act(), il1, q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [5:0] lops[8] = '{6'h23, 6'h2B, 6'h00, 6'h04,
                            6'h02, 6'h08, 6'h0C, 6'h0D};
    logic [5:0] op;
    for (int pass = 0; pass < 2; pass++) begin
      lat = (pass == 0) ? 1 : 3;
      do_reset();
      for (int n = 0; n < 30; n++) begin
        op = lops[$urandom_range(0, 7)];
`ifndef ILLEGAL_OP_EN
        if ($urandom_range(0, 3) == 0) op = 6'($urandom);
`endif
        opcode = op;
        q.delete(); build(op, lat);
        for (int i = 0; i < q.size(); i++) begin
          nvec++;
          if (act() !== q[i]) begin
            nerr++;
            $display("FAIL rand l%0d op%h cyc%0d got %h want %h",
                     lat, op, i, act(), q[i]);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    lat = 1;
    reset = 1'b1;
    opcode = 6'h00;
    @(negedge clk);
    test_reset();
    test_lw_lat1();
    test_sw_lat3();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; directly upstream of the ALU control decoder.
- Decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback.
- Drives all datapath enables plus ALUOp and the andi/ori/addi flags that the ALU control decoder consumes.
- Handles a memory with a fixed, parameterised latency via a wait counter.

Parameters:
MEM_LAT, 1, memory access cycles per fetch, load or store (1..2^CNT_W)
CNT_W, 3, width of the memory wait counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction[31:26]; valid from DECODE onward
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write qualified by ALU zero (branch)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read
MemWrite  out  1  memory write
MemtoReg  out  1  writeback select: 1=MDR, 0=ALUOut
IRWrite  out  1  instruction register load
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  out  2  to ALU control decoder
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
RegWrite  out  1  register file write
RegDst  out  1  1=rd, 0=rt
andi  out  1  current instruction is andi
ori  out  1  current instruction is ori
addi  out  1  current instruction is addi
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
state  out  4  current state encoding (debug)

Behaviour:
- Registers: state (4b), wait counter cnt (CNT_W), andi/ori/addi flags.
- All other outputs are decoded combinationally from state and cnt (Moore). Any signal not listed for a state is 0.
- Reset: at the clock edge with reset=1, state=FETCH(0), cnt=0, flags=0. Applies mid-instruction with no partial completion.
- In the cycle after reset deasserts, outputs are the FETCH values.
- States, outputs and transitions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. When cnt==MEM_LAT-1: IRWrite=1, PCWrite=1, PCSource=00, go to DECODE. Otherwise cnt++.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Flags latched from opcode (001100 andi, 001101 ori, 001000 addi). Next state by opcode: 100011/101011 MEMADR; 000000 EXECUTE; 000100 BRANCH; 000010 JUMP; 001000/001100/001101 IMM_EXEC; other opcode see Optional Feature.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw goes to MEMREAD, sw goes to MEMWRITE.
  - MEMREAD(3): MemRead=1, IorD=1 for MEM_LAT cycles, then MEMWB.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, then FETCH.
  - MEMWRITE(5): MemWrite=1, IorD=1 for MEM_LAT cycles. instr_done=1 on the last cycle, then FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RTYPE_WB.
  - RTYPE_WB(7): RegWrite=1, RegDst=1, instr_done=1, then FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, then FETCH.
  - JUMP(9): PCWrite=1, PCSource=10, instr_done=1, then FETCH.
  - IMM_EXEC(10): ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi/ori (the flags select the operation). Then IMM_WB.
  - IMM_WB(11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, then FETCH.
- Wait counter: cnt is 0 on entry to FETCH/MEMREAD/MEMWRITE and clears on exit. MEM_LAT=1 gives a single cycle with no wait.
- Flags hold from DECODE exit through the instruction's last cycle and are cleared on entry to FETCH.
- Unused encodings 12-15 go to FETCH on the next edge with all outputs 0.

Optional Feature:
- ILLEGAL_OP_EN defined: an unrecognised opcode in DECODE goes to TRAP(12).
  - TRAP is held until reset; all enables are 0.
  - Extra output port illegal_op is 1 only in TRAP (reset 0).
- ILLEGAL_OP_EN undefined: an unrecognised opcode is a NOP.
  - DECODE goes to FETCH with instr_done=1 in DECODE.
  - No illegal_op port.

Test Plan:
- MEM_LAT=1, reset 2 cycles then lw (100011) -> states 0,1,2,3,4; RegWrite and MemtoReg=1 only in cycle 5; instr_done pulses once in cycle 5.
- MEM_LAT=3, sw (101011) -> FETCH for 3 cycles with IRWrite/PCWrite only on the 3rd; MEMWRITE for 3 cycles; 8 cycles total; instr_done on the last cycle only.
- R-type (000000) then beq (000100) back to back -> ALUOp 10 in EXECUTE, 01 in BRANCH; PCWriteCond=1 only in BRANCH; 4+3 cycles.
- andi (001100), ori, addi in sequence -> ALUOp 11 with andi=1 / 11 with ori=1 / 00 with addi=1 in IMM_EXEC; exactly one flag high per instruction; all flags 0 in each following FETCH.
- Reset asserted during MEMREAD with MEM_LAT=3, cnt=1 -> next edge state=0, cnt=0, flags 0; no RegWrite ever asserted; a fresh fetch follows.
- opcode 111111 -> with ILLEGAL_OP_EN: state 12, illegal_op=1 held for 10+ cycles until reset. Without it: back to FETCH with instr_done=1 in DECODE.
